fetch_sequencer: RTL
====================

# fetch_sequencer

Instruction-fetch controller that sequences the program counter and the synchronous instruction memory. It issues one read per PC value and waits out the memory latency. It presents the fetched word to decode through a valid/ready handshake, then pulses the counter's increment input to advance. Fetch halts permanently on a HALT opcode.

## Interface
- ADDR_W, 8: PC/memory address width; must equal the counter's SIZE.
- DATA_W, 16: instruction width, ≥ 4.
- MEM_LAT, 1: instruction-memory read latency in cycles, legal 1..4.
- HALT_OP, 4'hF: opcode value in instr[DATA_W-1:DATA_W-4] that stops fetch.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- run  in  1  level; 1 = fetch enabled
- pc  in  ADDR_W  current counter value
- pc_incr  out  1  counter increment request (counter advances on its rising edge)
- mem_rd  out  1  memory read strobe
- mem_addr  out  ADDR_W  read address
- mem_rdata  in  DATA_W  read data, valid MEM_LAT cycles after the mem_rd cycle
- instr  out  DATA_W  fetched instruction
- instr_valid  out  1  instr is valid
- instr_ready  in  1  decode accepts instr
- busy  out  1  state ≠ IDLE and ≠ HALT
- halted  out  1  HALT state

## Operation
- States: IDLE, REQ, WAIT, PRESENT, ADVANCE, HALT.
- IDLE: all strobes 0. If run=1, go to REQ.
- REQ (1 cycle): mem_rd=1 and mem_addr=pc. Load the wait counter with MEM_LAT-1. Go to WAIT.
- WAIT (MEM_LAT cycles): when counter=0, register mem_rdata into instr and go to PRESENT. Otherwise decrement.
- PRESENT: instr_valid=1; instr is held stable until the handshake. On instr_valid & instr_ready:
  - opcode = HALT_OP: go to HALT; pc is not incremented.
  - otherwise: go to ADVANCE.
- ADVANCE (1 cycle): pc_incr=1. Next state is REQ if run=1, else IDLE.
- pc_incr is high only in ADVANCE. The REQ or IDLE cycle that follows guarantees a low cycle between increments, which the counter's edge detection needs.
- HALT: sticky until reset. halted=1 and all strobes 0; run is ignored.
- run=0 outside IDLE:
  - the fetch in flight completes;
  - its handshake is still required;
  - return to IDLE after ADVANCE.
- mem_addr is driven by pc in every state; only the REQ cycle is meaningful.
- pc wraps from 2^ADDR_W-1 to 0. This is the counter's behaviour; the sequencer treats wrap as normal.

## Timing
- Reset (async, immediate):
  - state=IDLE;
  - instr=0, instr_valid=0, pc_incr=0, mem_rd=0, busy=0, halted=0.
- Let REQ be cycle t:
  - capture edge at the end of cycle t+MEM_LAT;
  - instr_valid high from cycle t+MEM_LAT+1.
- Throughput with instr_ready tied high: one instruction per MEM_LAT+3 cycles (REQ, MEM_LAT×WAIT, PRESENT, ADVANCE). MEM_LAT=1 gives 4 cycles.
- pc updates at the edge ending ADVANCE. The next REQ therefore sees the new pc.
- An instr_ready stall holds PRESENT indefinitely. No memory read and no pc_incr occur during the stall.
- Reset asserted during WAIT discards the pending read data. The counter shares this reset and returns pc to 0.
- run rising during HALT has no effect.

## Structure
- Shared package `fetch_pkg`:
  - state enum fetch_state_t;
  - default HALT_OP constant;
  - opcode field position constants.
- One sub-module, `fetch_wait_timer`: a 2-bit down-counter with load and zero flag, used for the WAIT phase.
- The FSM, instr register and output decode live in fetch_sequencer.
- The counter instance stays outside; the integration top connects pc_incr to the counter's incr and the counter's out to pc.

## Test plan
- Reset with run=1, MEM_LAT=1, ready=1; memory holds 0x1000, 0x2001, 0x3002 at addresses 0..2. Require:
  - instr sequence 0x1000, 0x2001, 0x3002;
  - instr_valid pulses 4 cycles apart;
  - pc reads 0, 1, 2, 3.
- MEM_LAT=3 → first instr_valid 4 cycles after the first mem_rd, and one instruction every 6 cycles.
- Hold instr_ready=0 for 5 cycles during PRESENT → during the stall:
  - instr is stable and instr_valid=1;
  - mem_rd=0 and pc_incr=0;
  - pc is unchanged.
- Word 0xF123 at address 2 → after its handshake:
  - halted=1 and pc stays 2;
  - no further mem_rd, including after a run toggle.
- Drop run while in WAIT → the instruction still presents; after its handshake one pc_incr, then IDLE with busy=0. Raising run resumes at pc+1.
- Assert reset in WAIT with MEM_LAT=4 → outputs clear immediately. After release, the first fetch is from address 0 and returns the correct word.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM state
// encoding, the default HALT opcode and the position of the opcode field.
package fetch_pkg;

    // Fetch FSM states. The explicit encoding lets legacy code keep using
    // plain 3-bit constants.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_ADVANCE = 3'd4,
        ST_HALT    = 3'd5
    } fetch_state_t;

    // The opcode occupies the top OPCODE_W bits of an instruction word.
    localparam int OPCODE_W = 4;

    // Opcode that stops fetch for good.
    localparam logic [OPCODE_W-1:0] HALT_OP_DEFAULT = 4'hF;

    // Width of the memory-latency down-counter (latency 1..4 -> preload 0..3).
    localparam int WAIT_CNT_W = 2;

    // Bit index of the opcode field's least significant bit.
    function automatic int opcode_lsb(input int data_w);
        return data_w - OPCODE_W;
    endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Small down-counter that times the instruction-memory latency.
// Loaded with (latency - 1) during the read request; zero marks the cycle
// in which the read data is on the bus.
module fetch_wait_timer
    import fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WAIT_CNT_W-1:0] load_value,
    input  logic                  decrement,
    output logic                  zero
);

    logic [WAIT_CNT_W-1:0] count;

    // Load takes priority; decrement saturates at zero so the flag stays
    // valid if the controller lingers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (decrement && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller. Issues one memory read per pc value, waits
// out the memory latency, presents the word to decode over valid/ready and
// then pulses the external counter's increment input. A HALT opcode stops
// fetch until reset. The pc counter itself lives outside this block.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                   ADDR_W  = 8,
    parameter int                   DATA_W  = 16,
    parameter int                   MEM_LAT = 1,
    parameter logic [OPCODE_W-1:0]  HALT_OP = HALT_OP_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_incr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              busy,
    output logic              halted
);

    localparam logic [2:0] IDLE    = ST_IDLE;
    localparam logic [2:0] REQ     = ST_REQ;
    localparam logic [2:0] WAIT    = ST_WAIT;
    localparam logic [2:0] PRESENT = ST_PRESENT;
    localparam logic [2:0] ADVANCE = ST_ADVANCE;
    localparam logic [2:0] HALT    = ST_HALT;

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(MEM_LAT - 1);
    localparam int                    OP_LSB    = opcode_lsb(DATA_W);

    logic [2:0]          state;
    logic [2:0]          state_next;
    logic                timer_load;
    logic                timer_dec;
    logic                timer_zero;
    logic                handshake;
    logic                capture;
    logic [OPCODE_W-1:0] opcode;

    assign timer_load = (state == REQ);
    assign timer_dec  = (state == WAIT) && !timer_zero;
    assign capture    = (state == WAIT) && timer_zero;
    assign handshake  = instr_valid && instr_ready;
    assign opcode     = instr[OP_LSB +: OPCODE_W];

    fetch_wait_timer u_wait_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (WAIT_LOAD),
        .decrement  (timer_dec),
        .zero       (timer_zero)
    );

    // Next-state logic. run is only sampled in IDLE and ADVANCE, so a fetch
    // already in flight always runs to completion including its handshake.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (run) state_next = REQ;
            REQ:     state_next = WAIT;
            WAIT:    if (timer_zero) state_next = PRESENT;
            PRESENT: begin
                if (handshake) begin
                    state_next = (opcode == HALT_OP) ? HALT : ADVANCE;
                end
            end
            ADVANCE: state_next = run ? REQ : IDLE;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset drops any read in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Instruction register: captured in the cycle the read data is valid,
    // then held stable through any decode stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr <= '0;
        end else if (capture) begin
            instr <= mem_rdata;
        end
    end

    // Output decode. pc_incr is high only in ADVANCE; the REQ or IDLE cycle
    // after it gives the counter's edge detector its low cycle.
    assign mem_rd      = (state == REQ);
    assign mem_addr    = pc;
    assign instr_valid = (state == PRESENT);
    assign pc_incr     = (state == ADVANCE);
    assign halted      = (state == HALT);
    assign busy        = (state != IDLE) && (state != HALT);

endmodule
